// File: rtl/dac_update_scheduler_pkg.sv
// Shared types and sizes for the DAC update scheduler.
package dac_update_scheduler_pkg;
  localparam int NUM_CH = 4;
  localparam int CODE_W = 12;
  localparam int ADDR_W = 2;
  localparam int CNT_W  = 16;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_GAP
  } state_t;
endpackage

// File: rtl/dac_update_scheduler_rr.sv
// Four-way round-robin arbiter: nearest requester after last wins.
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] grant,
  output logic       valid
);
  logic [1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    // farthest first so the nearest hit overwrites it
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dac_update_scheduler.sv
// Arbitrates shadowed channel writes and clears onto the DAC driver.
module dac_update_scheduler
  import dac_update_scheduler_pkg::*;
#(
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              FPGA_CLK_I,
  input  logic              RESET_N_I,
  input  logic              WR_EN_I,
  input  logic [ADDR_W-1:0] WR_ADDR_I,
  input  logic [CODE_W-1:0] WR_DATA_I,
  input  logic              CLR_REQ_I,
  input  logic              DAC_IDLE_I,
  output logic              DAC_EN_O,
  output logic              DAC_CLR_O,
  output logic [ADDR_W-1:0] DAC_ADDR_O,
  output logic [CODE_W-1:0] DAC_DATA_O,
  output logic              BUSY_O,
  output logic [NUM_CH-1:0] PENDING_O,
  output logic              CLR_PEND_O,
  output logic              ERR_O
);
  localparam cnt_t GAP_LD = cnt_t'(GAP_CYCLES);
  localparam cnt_t TMO_LD = cnt_t'(ACK_TIMEOUT);

  state_t            state, state_n;
  cnt_t              gap_cnt, gap_n;
  cnt_t              tmo_cnt, tmo_n;
  logic              err, err_n;
  logic              sel_clr, sel_ch, issue;
  logic [CODE_W-1:0] shadow [NUM_CH];
  logic [NUM_CH-1:0] dirty;
  logic              clr_pend;
  logic [ADDR_W-1:0] last;
  logic [ADDR_W-1:0] gnt;
  logic              gnt_v;

  rr_arbiter4 u_arb (
    .req   (dirty),
    .last  (last),
    .grant (gnt),
    .valid (gnt_v)
  );

  always_ff @(posedge FPGA_CLK_I) begin
    if (!RESET_N_I) begin
      state   <= S_IDLE;
      gap_cnt <= '0;
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      gap_cnt <= gap_n;
      tmo_cnt <= tmo_n;
      err     <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    gap_n   = gap_cnt;
    tmo_n   = tmo_cnt;
    err_n   = err;
    sel_clr = 1'b0;
    sel_ch  = 1'b0;
    issue   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (DAC_IDLE_I && clr_pend) begin
          sel_clr = 1'b1;
          state_n = S_ISSUE;
        end else if (DAC_IDLE_I && gnt_v) begin
          sel_ch  = 1'b1;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        issue   = 1'b1;
        tmo_n   = TMO_LD;
        state_n = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (!DAC_IDLE_I) begin
          state_n = S_WAIT_DONE;
        end else if (tmo_cnt < cnt_t'(2)) begin
          tmo_n   = '0;
          err_n   = 1'b1;
          gap_n   = GAP_LD;
          state_n = S_GAP;
        end else begin
          tmo_n = tmo_cnt - cnt_t'(1);
        end
      end
      S_WAIT_DONE: begin
        if (DAC_IDLE_I) begin
          gap_n   = GAP_LD;
          state_n = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) state_n = S_IDLE;
        else gap_n = gap_cnt - cnt_t'(1);
      end
      default: state_n = S_IDLE;
    endcase
  end

  // host updates come last so a write in the issue cycle keeps its bit set
  always_ff @(posedge FPGA_CLK_I) begin
    if (!RESET_N_I) begin
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
      dirty      <= '0;
      clr_pend   <= 1'b0;
      last       <= 2'd3;
      DAC_CLR_O  <= 1'b0;
      DAC_ADDR_O <= '0;
      DAC_DATA_O <= '0;
    end else begin
      if (sel_clr) begin
        DAC_CLR_O  <= 1'b1;
        DAC_ADDR_O <= '0;
        DAC_DATA_O <= '0;
      end else if (sel_ch) begin
        DAC_CLR_O  <= 1'b0;
        DAC_ADDR_O <= gnt;
        DAC_DATA_O <= shadow[gnt];
        last       <= gnt;
      end
      if (issue) begin
        if (DAC_CLR_O) clr_pend <= 1'b0;
        else dirty[DAC_ADDR_O] <= 1'b0;
      end
      if (WR_EN_I) begin
        shadow[WR_ADDR_I] <= WR_DATA_I;
        dirty[WR_ADDR_I]  <= 1'b1;
      end
      if (CLR_REQ_I) clr_pend <= 1'b1;
    end
  end

  assign DAC_EN_O   = (state == S_ISSUE);
  assign BUSY_O     = (state != S_IDLE);
  assign PENDING_O  = dirty;
  assign CLR_PEND_O = clr_pend;
  assign ERR_O      = err;
endmodule

// File: tb/tb_dac_update_scheduler.sv
// Scoreboard bench: pending-set model predicts each issued operation.
module tb_dac_update_scheduler;
  localparam int GAP = 4;
  localparam int TMO = 16;

  typedef struct packed {
    logic        clr;
    logic [1:0]  addr;
    logic [11:0] data;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n   = 1'b0;
  logic        wr_en   = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        clr_req = 1'b0;
  logic        dac_idle;
  logic        dac_en, dac_clr, busy, clr_pend, err;
  logic [1:0]  dac_addr;
  logic [11:0] dac_data;
  logic [3:0]  pending;

  dac_update_scheduler #(.GAP_CYCLES(GAP), .ACK_TIMEOUT(TMO)) dut (
    .FPGA_CLK_I (clk),
    .RESET_N_I  (rst_n),
    .WR_EN_I    (wr_en),
    .WR_ADDR_I  (wr_addr),
    .WR_DATA_I  (wr_data),
    .CLR_REQ_I  (clr_req),
    .DAC_IDLE_I (dac_idle),
    .DAC_EN_O   (dac_en),
    .DAC_CLR_O  (dac_clr),
    .DAC_ADDR_O (dac_addr),
    .DAC_DATA_O (dac_data),
    .BUSY_O     (busy),
    .PENDING_O  (pending),
    .CLR_PEND_O (clr_pend),
    .ERR_O      (err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // driver model: idle drops the cycle after EN, for blen cycles
  int   busy_cnt = 0;
  int   blen = 3;
  logic stuck = 1'b0;
  logic rnd_len = 1'b0;
  always @(posedge clk) begin
    if (dac_en && !stuck)
      busy_cnt <= rnd_len ? int'($urandom_range(5, 1)) : blen;
    else if (busy_cnt > 0)
      busy_cnt <= busy_cnt - 1;
  end
  assign dac_idle = (busy_cnt == 0);

  logic        s_rst = 1'b0, s_wr = 1'b0, s_clr = 1'b0;
  logic [1:0]  s_addr = '0;
  logic [11:0] s_data = '0;
  always @(posedge clk) begin
    s_rst  <= rst_n;
    s_wr   <= wr_en;
    s_addr <= wr_addr;
    s_data <= wr_data;
    s_clr  <= clr_req;
  end

  // reference model: pending set, latest codes, round-robin pointer
  txn_t        exp_q[$];
  logic [11:0] m_shadow [4];
  logic [3:0]  m_dirty = '0;
  logic        m_clr = 1'b0;
  int          m_last = 3;
  logic        iss_v = 1'b0;
  txn_t        iss_t, m_t;
  logic        found;

  initial forever begin
    @(negedge clk);
    if (!s_rst) begin
      m_dirty = '0;
      m_clr   = 1'b0;
      m_last  = 3;
      iss_v   = 1'b0;
      for (int i = 0; i < 4; i++) m_shadow[i] = '0;
    end else begin
      if (iss_v) begin
        if (iss_t.clr) m_clr = 1'b0;
        else m_dirty[iss_t.addr] = 1'b0;
        iss_v = 1'b0;
      end
      if (dac_en) begin
        chk("en_has_work", 32'({m_clr, m_dirty} != 0), 1);
        m_t = '0;
        if (m_clr) begin
          m_t.clr = 1'b1;
        end else begin
          found = 1'b0;
          for (int k = 1; k <= 4; k++) begin
            if (!found && m_dirty[(m_last + k) % 4]) begin
              found    = 1'b1;
              m_t.addr = 2'((m_last + k) % 4);
            end
          end
          m_t.data = m_shadow[m_t.addr];
          m_last   = int'(m_t.addr);
        end
        exp_q.push_back(m_t);
        iss_v = 1'b1;
        iss_t = m_t;
      end
      if (s_wr) begin
        m_shadow[s_addr] = s_data;
        m_dirty[s_addr]  = 1'b1;
      end
      if (s_clr) m_clr = 1'b1;
    end
    chk("pending", 32'(pending), 32'(m_dirty));
    chk("clr_pend", 32'(clr_pend), 32'(m_clr));
  end

  // monitor: pops on every EN, checks timing and hold behaviour
  int         cyc = 0, rise_cyc = 0;
  logic       rise_v = 1'b0, prev_idle = 1'b1, prev_en = 1'b0;
  logic       have_last = 1'b0;
  txn_t       last_t, got, e_t;
  logic [2:0] iss_log[$];

  initial forever begin
    @(negedge clk);
    #1;
    cyc++;
    if (!s_rst) begin
      rise_v    = 1'b0;
      have_last = 1'b0;
      prev_en   = 1'b0;
      prev_idle = dac_idle;
    end else begin
      got = {dac_clr, dac_addr, dac_data};
      if (dac_idle && !prev_idle && busy) begin
        rise_cyc = cyc;
        rise_v   = 1'b1;
        if (have_last) chk("hold_outputs", 32'(got), 32'(last_t));
      end
      if (dac_en) begin
        chk("en_single_pulse", 32'(prev_en), 0);
        chk("busy_in_issue", 32'(busy), 1);
        if (rise_v) chk("gap_respected", 32'((cyc - rise_cyc) >= GAP + 1), 1);
        chk("exp_q_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e_t = exp_q.pop_front();
          chk("txn", 32'(got), 32'(e_t));
        end
        last_t    = got;
        have_last = 1'b1;
        rise_v    = 1'b0;
        iss_log.push_back({dac_clr, dac_addr});
      end
      prev_en   = dac_en;
      prev_idle = dac_idle;
    end
  end

  task automatic wr(input logic [1:0] a, input logic [11:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic clr_pulse();
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
  endtask

  task automatic wait_en(input int bound);
    int k = 0;
    while (!dac_en && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("wait_en", 32'(dac_en), 1);
  endtask

  task automatic wait_quiet(input int bound);
    int k = 0;
    while ((busy || pending != 0 || clr_pend) && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("quiet", 32'(busy || pending != 0 || clr_pend), 0);
  endtask

  // entry i of exp is {clr, addr} in bits [3i+2:3i]
  task automatic check_log(input string nm, input int n, input logic [11:0] exp);
    chk({nm, "_len"}, 32'(iss_log.size()), 32'(n));
    if (iss_log.size() == n)
      for (int i = 0; i < n; i++) chk(nm, 32'(iss_log[i]), 32'(exp[3*i +: 3]));
    iss_log.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({dac_en, dac_clr, dac_addr, dac_data, busy,
                              pending, clr_pend, err}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    wr(2'd2, 12'hABC);
    chk("t1_pending", 32'(pending), 32'h4);
    chk("t1_no_early_en", 32'(dac_en), 0);
    @(negedge clk);
    chk("t1_en_latency", 32'(dac_en), 1);
    chk("t1_txn", 32'({dac_clr, dac_addr, dac_data}), 32'({1'b0, 2'd2, 12'hABC}));
    @(negedge clk);
    chk("t1_pending_clr", 32'(pending), 0);
    wait_quiet(100);
    iss_log.delete();

    blen = 3;
    wr(2'd0, 12'h001);
    wr(2'd1, 12'h002);
    wr(2'd2, 12'h003);
    wr(2'd3, 12'h004);
    wait_quiet(300);
    check_log("t2_order", 4, {3'd3, 3'd2, 3'd1, 3'd0});

    blen = 12;
    wr(2'd0, 12'h010);
    wait_en(10);
    wr(2'd1, 12'h111);
    wr(2'd3, 12'h333);
    clr_pulse();
    wait_quiet(400);
    check_log("t3_order", 4, {3'd3, 3'd1, 3'b100, 3'd0});

    blen = 10;
    wr(2'd0, 12'h0AA);
    wait_en(10);
    wr(2'd1, 12'h100);
    wr(2'd1, 12'h200);
    wait_en(100);
    chk("t4_last_value", 32'(dac_data), 32'h200);
    wr(2'd1, 12'h300);
    wait_quiet(400);
    check_log("t4_order", 3, {3'd0, 3'd1, 3'd1, 3'd0});

    stuck = 1'b1;
    wr(2'd2, 12'h222);
    wait_en(10);
    chk("t5_err_before", 32'(err), 0);
    k = 0;
    while (!err && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("t5_timeout_cycles", 32'(k), 32'(TMO + 1));
    stuck = 1'b0;
    blen  = 3;
    wr(2'd3, 12'h333);
    wait_quiet(200);
    chk("t5_err_sticky", 32'(err), 1);
    check_log("t5_order", 2, {6'd0, 3'd3, 3'd2});

    blen = 3;
    wr(2'd1, 12'h0F1);
    wait_en(10);
    repeat (2) @(negedge clk);
    chk("t6_in_wait_done", 32'({busy, dac_idle}), 32'b10);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_reset_outputs", 32'({dac_en, dac_clr, dac_addr, dac_data, busy,
                                 pending, clr_pend, err}), 0);
    rst_n = 1'b1;
    k = 0;
    while (!dac_idle && k < 20) begin
      @(negedge clk);
      k++;
    end
    iss_log.delete();
    wr(2'd3, 12'h0C3);
    wr(2'd0, 12'h0C0);
    wait_quiet(200);
    check_log("t6_order", 2, {6'd0, 3'd0, 3'd3});

    rnd_len = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      wr_en   = ($urandom % 4) == 0;
      wr_addr = 2'($urandom);
      wr_data = 12'($urandom);
      clr_req = ($urandom % 24) == 0;
      @(negedge clk);
    end
    wr_en   = 1'b0;
    clr_req = 1'b0;
    wait_quiet(3000);
    repeat (2) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
